// File: rtl/gen_v2_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Package : gen_v2_pkg                                                     |
// | Purpose : Shared constants, FIFO entry layout and the sample-to-pixel    |
// |           conversion used by the generator_v2 output framer.             |
// | Contents: DATA_WIDTH/FRAC_BITS/OUT_WIDTH/IMG_W/IMG_H, counter widths,    |
// |           fifo_entry_t {sof, eol, eof, pix}, to_pixel().                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package gen_v2_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int OUT_WIDTH  = 8;
  localparam int IMG_W      = 32;
  localparam int IMG_H      = 32;

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Right shift that maps the (FRAC_BITS+1)-bit [0, 2.0) range onto OUT_WIDTH bits.
  localparam int SHIFT   = FRAC_BITS + 1 - OUT_WIDTH;
  localparam int PIX_MAX = (1 << OUT_WIDTH) - 1;

  typedef struct packed {
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic [OUT_WIDTH-1:0] pix;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Offset a tanh-range sample by +1.0, rescale, and saturate to an
  // unsigned pixel. Truncating shift, no rounding.
  function automatic logic [OUT_WIDTH-1:0] to_pixel(input logic signed [DATA_WIDTH-1:0] s);
    logic signed [DATA_WIDTH:0] sum;
    logic signed [DATA_WIDTH:0] sh;
    logic signed [DATA_WIDTH:0] pix_max_s;
    pix_max_s = (DATA_WIDTH + 1)'(PIX_MAX);
    sum       = {s[DATA_WIDTH-1], s} + (DATA_WIDTH + 1)'(1 << FRAC_BITS);
    sh        = sum >>> SHIFT;
    if (sh[DATA_WIDTH]) begin
      return '0;
    end else if (sh > pix_max_s) begin
      return '1;
    end else begin
      return sh[OUT_WIDTH-1:0];
    end
  endfunction

endpackage : gen_v2_pkg
`default_nettype wire

// File: rtl/gen_v2_output_framer_fifo.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Module  : sync_fifo_fwft                                                 |
// | Purpose : Synchronous first-word-fall-through FIFO. The head entry is    |
// |           visible on rdata whenever empty is low. A push while full is   |
// |           accepted only if a pop happens in the same cycle.              |
// | Ports   : clk, rst_n (async, active-low), clr (sync clear)               |
// |           push/wdata  - write request and data                           |
// |           pop         - consume head (ignored when empty)                |
// |           rdata       - head entry                                       |
// |           full/empty  - occupancy flags                                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sync_fifo_fwft #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_wr;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign rdata = r_mem[r_rd_ptr];

  assign w_pop = pop && !empty;
  // When full, the slot being written is the one the pop frees this cycle.
  assign w_wr  = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/gen_v2_output_framer.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Module  : gen_v2_output_framer                                           |
// | Purpose : Converts generator_v2 signed samples to unsigned pixels, tags  |
// |           frame position (sof/eol/eof), buffers them in an FWFT FIFO and |
// |           presents a ready/valid master stream. Counts completed frames  |
// |           and flags pixels lost to FIFO overflow.                        |
// | Ports   : clk, rst_n (async, active-low), clr (sync soft clear)          |
// |           valid_in/data_in          - input stream, no backpressure      |
// |           m_valid/m_ready/m_data    - output pixel handshake             |
// |           m_sof/m_eol/m_eof         - position tags of head pixel        |
// |           frame_done                - pulse after eof pixel transfers    |
// |           frame_count               - completed frames, mod 2^16         |
// |           overflow                  - sticky, a pixel was dropped        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module gen_v2_output_framer
  import gen_v2_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  overflow
);

  if (FRAC_BITS + 1 < OUT_WIDTH) begin : g_bad_frac
    $error("gen_v2_output_framer: FRAC_BITS+1 must be >= OUT_WIDTH");
  end

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_s1_valid;
  fifo_entry_t        r_s1_entry;
  logic               r_frame_done;
  logic [15:0]        r_frame_count;
  logic               r_overflow;

  logic               w_last_col;
  logic               w_last_row;
  logic [ENTRY_W-1:0] w_rdata;
  fifo_entry_t        w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;

  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));

  // Stage S1: convert and tag. Position advances on every input sample,
  // whether or not the FIFO later accepts it, so framing tracks the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_entry <= '0;
    end else if (clr) begin
      r_col      <= '0;
      r_row      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_entry <= '0;
    end else begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_s1_entry.pix <= to_pixel(data_in);
        r_s1_entry.sof <= (r_col == '0) && (r_row == '0);
        r_s1_entry.eol <= w_last_col;
        r_s1_entry.eof <= w_last_col && w_last_row;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (r_s1_valid),
    .wdata (r_s1_entry),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head = fifo_entry_t'(w_rdata);
  assign w_pop  = m_valid && m_ready;
  assign w_drop = r_s1_valid && w_full && !w_pop;

  // Everything is gated by m_valid so an empty FIFO presents all zeros.
  assign m_valid = !w_empty;
  assign m_data  = m_valid ? w_head.pix : '0;
  assign m_sof   = m_valid && w_head.sof;
  assign m_eol   = m_valid && w_head.eol;
  assign m_eof   = m_valid && w_head.eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
    end else if (clr) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_done <= w_pop && w_head.eof;
      if (w_pop && w_head.eof) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;

endmodule : gen_v2_output_framer
`default_nettype wire

// File: tb/tb_gen_v2_output_framer.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_gen_v2_output_framer                                        |
// | Purpose : Directed self-checking bench for gen_v2_output_framer.         |
// |           Inputs change on the falling edge; outputs are sampled there.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_gen_v2_output_framer;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clr      = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] data_in  = '0;
  logic        m_ready  = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_eof;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          in_idx  = 0;
  int          n_fd    = 0;
  int          n_out   = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  gen_v2_output_framer #(
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .m_eof       (m_eof),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Input that maps exactly onto pixel value k (0..255).
  function automatic logic [15:0] px2din(input int k);
    return 16'(k * 2 - 256);
  endfunction

  // Expected {sof, eol, eof, pix} for the idx-th input sample since reset/clr.
  function automatic logic [10:0] exp_ent(input int idx, input int pix);
    int pos;
    pos = idx % 1024;
    return {(pos == 0), ((pos % 32) == 31), (pos == 1023), 8'(pix)};
  endfunction

  // One clock: drive inputs on the falling edge and log the transfer that
  // the next rising edge will perform.
  task automatic step(input logic v, input logic [15:0] d, input logic rdy);
    logic [10:0] e;
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    m_ready  = rdy;
    if (m_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_out", {m_sof, m_eol, m_eof, m_data}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("out[%0d]", n_out), {21'b0, m_sof, m_eol, m_eof, m_data}, {21'b0, e});
      end
      n_out++;
    end
    if (frame_done) n_fd++;
  endtask

  task automatic send(input logic [15:0] d, input int pix, input logic rdy, input logic keep);
    if (keep) exp_q.push_back(exp_ent(in_idx, pix));
    step(1'b1, d, rdy);
    in_idx++;
  endtask

  task automatic sendk(input int k, input logic rdy, input logic keep);
    send(px2din(k), k, rdy, keep);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(1'b0, 16'h0, 1'b1);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
  endtask

  task automatic clear();
    @(negedge clk);
    valid_in = 1'b0;
    m_ready  = 1'b0;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    in_idx = 0;
    n_fd   = 0;
    check("clr_valid", m_valid, 0);
    check("clr_ovf", overflow, 0);
    check("clr_fcnt", frame_count, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sv[7];
    int          sp[7];
    sv = '{16'h0000, 16'h0100, 16'hFF00, 16'h0080, 16'h7FFF, 16'h8000, 16'hFE80};
    sp = '{128, 255, 0, 192, 255, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_tags", {m_sof, m_eol, m_eof}, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcnt", frame_count, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // Conversion sweep with two-edge latency check
    send(sv[0], sp[0], 1'b1, 1'b1);
    send(sv[1], sp[1], 1'b1, 1'b1);
    check("lat_edge1", m_valid, 0);
    send(sv[2], sp[2], 1'b1, 1'b1);
    check("lat_edge2", m_valid, 1);
    for (int i = 3; i < 7; i++) send(sv[i], sp[i], 1'b1, 1'b1);
    drain();

    // Full frame
    clear();
    for (int i = 0; i < 1024; i++) sendk(i % 256, 1'b1, 1'b1);
    drain();
    check("ff_done_pulses", n_fd, 1);
    check("ff_fcnt", frame_count, 1);

    // Backpressure
    clear();
    for (int k = 1; k <= 10; k++) sendk(k, 1'b0, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 1);
    check("bp_sof", m_sof, 1);
    step(1'b0, 16'h0, 1'b0);
    check("bp_head_hold", m_data, 1);
    drain();
    check("bp_ovf", overflow, 0);
    check("bp_empty", m_valid, 0);

    // Clear mid-frame discards contents and position
    clear();
    for (int k = 1; k <= 5; k++) sendk(k, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("preclr_valid", m_valid, 1);
    clear();
    sendk(7, 1'b1, 1'b1);
    drain();

    // Full FIFO with simultaneous push and pop
    clear();
    for (int k = 1; k <= 17; k++) sendk(k, 1'b0, 1'b1);
    for (int k = 18; k <= 24; k++) sendk(k, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check("fpp_ovf", overflow, 0);
    n_out = 0;
    drain();
    check("fpp_remaining", n_out, 16);

    // Overflow, then framing stays aligned to the input stream
    clear();
    for (int k = 1; k <= 20; k++) sendk(k, 1'b0, (k <= 16));
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("ovf_flag", overflow, 1);
    n_out = 0;
    drain();
    check("ovf_delivered", n_out, 16);
    for (int i = 20; i <= 1024; i++) sendk(i % 256, 1'b1, 1'b1);
    drain();
    check("ovf_fcnt", frame_count, 1);
    check("ovf_sticky", overflow, 1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 500; i++) sendk(i % 256, 1'b1, 1'b1);
    check("prerst_valid", m_valid, 1);
    check("prerst_fcnt", frame_count, 1);
    #2;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_data", m_data, 0);
    check("arst_tags", {m_sof, m_eol, m_eof}, 0);
    check("arst_done", frame_done, 0);
    check("arst_fcnt", frame_count, 0);
    check("arst_ovf", overflow, 0);
    exp_q.delete();
    in_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    sendk(9, 1'b1, 1'b1);
    drain();
    check("postrst_fcnt", frame_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gen_v2_output_framer
`default_nettype wire

// File: doc/gen_v2_output_framer.md
Name: gen_v2_output_framer

Overview:
- Sits directly downstream of generator_v2 and consumes its free-running valid/data pixel stream, which has no backpressure.
- Converts each signed fixed-point tanh-range sample to an unsigned 8-bit pixel and tags it with frame position (sof/eol/eof).
- Buffers tagged pixels in a FWFT FIFO and presents them on a ready/valid master interface to the frame writer / host DMA.
- Counts completed frames and flags any pixels lost to FIFO overflow.

Parameters:
- DATA_WIDTH, 16, width of the incoming signed sample.
- FRAC_BITS, 8, fractional bits of the incoming sample; the constraint FRAC_BITS+1 >= OUT_WIDTH is enforced.
- OUT_WIDTH, 8, output pixel width.
- IMG_W, 32, pixels per row.
- IMG_H, 32, rows per frame.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous soft clear; same effect as reset.
- valid_in  in  1  input sample strobe from generator_v2; no backpressure.
- data_in  in  DATA_WIDTH  signed input sample.
- m_valid  out  1  output pixel available.
- m_ready  in  1  downstream accepts; a transfer occurs when m_valid && m_ready.
- m_data  out  OUT_WIDTH  unsigned pixel.
- m_sof  out  1  pixel is (row 0, col 0).
- m_eol  out  1  pixel is col IMG_W-1.
- m_eof  out  1  pixel is (row IMG_H-1, col IMG_W-1).
- frame_done  out  1  one-cycle pulse when the eof pixel transfers.
- frame_count  out  16  number of completed frames; wraps modulo 2^16.
- overflow  out  1  sticky flag: at least one pixel was dropped.

Behaviour:
- Reset (rst_n low, async) and clr (sync) clear the following: FIFO empty, col=row=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, frame_done=0, frame_count=0, overflow=0.
- Conversion, in a 1-cycle registered stage S1:
  - sum = data_in + (1<<FRAC_BITS), computed signed on DATA_WIDTH+1 bits.
  - sh = sum >>> (FRAC_BITS+1-OUT_WIDTH), arithmetic shift, truncating with no rounding.
  - pix = 0 if sh<0, 2^OUT_WIDTH-1 if sh>2^OUT_WIDTH-1, else sh.
- Position tagging, at S1 capture:
  - Tags are computed from the current col/row.
  - Every valid_in advances col; col wraps from IMG_W-1 to 0 and increments row; row wraps from IMG_H-1 to 0.
  - Counters advance even when the pixel is later dropped, so framing stays aligned to the input stream.
- FIFO write: the S1 register (pixel + 3 tags, OUT_WIDTH+3 bits) is written the cycle after capture if S1 is valid.
- Latency: with the FIFO empty, valid_in sampled at edge N gives m_valid=1 immediately after edge N+1 (two-edge latency).
- Output: first-word-fall-through.
  - m_valid = !empty; m_data and tags reflect the head entry.
  - m_data and the tags are held stable while m_valid && !m_ready.
  - Tag outputs are 0 whenever m_valid=0.
- Full FIFO:
  - A write with full && !pop drops the entry and sets overflow=1 (sticky until reset/clr).
  - A write with full && pop is accepted and the count is unchanged.
- Empty FIFO: a pop with empty is impossible because m_valid=0; m_ready is ignored.
- Simultaneous push and pop at any occupancy: the count is unchanged and order is preserved.
- Completion: frame_done pulses in the cycle after the transfer of an entry with eof=1; frame_count increments at the same edge.
- Extra pixels after a frame (e.g. generator flush zeros) begin a new frame tagged from sof.
- Reset or clr mid-frame discards FIFO contents and partial-frame position; the next valid_in is tagged sof.

Decomposition:
- Package gen_v2_pkg holds:
  - the shared constants DATA_WIDTH, FRAC_BITS, OUT_WIDTH, IMG_W, IMG_H;
  - localparams for counter widths ($clog2);
  - the packed FIFO entry layout {sof, eol, eof, pix}.
- One sub-module, sync_fifo_fwft: parameterised width/depth, full/empty/count, simultaneous push/pop when full. The top module holds conversion, counters, and status.

Test Plan:
- Conversion sweep, m_ready=1: inputs 0x0000, 0x0100, 0xFF00, 0x0080, 0x7FFF, 0x8000, 0xFE80 -> m_data 128, 255, 0, 192, 255, 0, 0, in order, with m_valid 2 edges after each input.
- Full frame: 1024 consecutive valid_in, m_ready=1 -> sof only on pixel 0; eol on pixels 31, 63, ..., 1023; eof only on 1023; one frame_done pulse; frame_count=1.
- Backpressure: 10 pixels in with m_ready=0, then m_ready=1 -> m_valid held with head stable, then all 10 pixels out in order with no overflow.
- Overflow: 20 pixels in with m_ready=0 (depth 16) -> overflow=1 and only the first 16 delivered. The next frame's sof still lands on input pixel 1024.
- Full-plus-pop: fill 16, then push and pop together for 8 cycles -> no overflow, count stays 16, order preserved.
- Mid-frame reset: assert rst_n=0 after 500 pixels -> all outputs 0 immediately. After release, the first pixel carries sof and frame_count=0.
